// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU (ADD/SUB/AND/OR/XOR/MEAN/MIN/RELU) with NZCV flags, tag passthrough, sticky {C,V}
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       sticky_cv,
  input  logic             sticky_clr
);
  logic             r_s1_valid, r_s2_valid;
  logic [WIDTH-1:0] r_a, r_b, r_res;
  logic [2:0]       r_op;
  logic [TAG_W-1:0] r_tag1, r_tag2;
  logic [3:0]       r_flags;
  logic [1:0]       r_sticky;
  logic             w_s1_ready, w_s2_ready, w_c, w_v;
  logic [WIDTH:0]   w_sum, w_dif;
  logic [WIDTH-1:0] w_res;
  logic [3:0]       w_flags;
  assign w_s2_ready = !r_s2_valid || out_ready;
  assign w_s1_ready = !r_s1_valid || w_s2_ready;
  assign in_ready   = w_s1_ready;
  assign out_valid  = r_s2_valid;
  assign out_result = r_res;
  assign out_flags  = r_flags;
  assign out_tag    = r_tag2;
  assign sticky_cv  = r_sticky;
  assign w_sum = {1'b0, r_a} + {1'b0, r_b};
  assign w_dif = {1'b0, r_a} + {1'b0, ~r_b} + (WIDTH+1)'(1);
  always_comb begin
    w_res = r_a;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (r_op)
      3'd0: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      3'd1: begin
        w_res = w_dif[WIDTH-1:0];
        w_c   = w_dif[WIDTH];
        w_v   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_dif[WIDTH-1] != r_a[WIDTH-1]);
      end
      3'd2: w_res = r_a & r_b;
      3'd3: w_res = r_a | r_b;
      3'd4: w_res = r_a ^ r_b;
      3'd5: w_res = w_sum[WIDTH:1];
      3'd6: w_res = ($signed(r_a) < $signed(r_b)) ? r_a : r_b;
      default: w_res = r_a[WIDTH-1] ? '0 : r_a;
    endcase
  end
  assign w_flags = {w_res[WIDTH-1], w_res == '0, w_c, w_v};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
      r_tag1     <= '0;
      r_s2_valid <= 1'b0;
      r_res      <= '0;
      r_flags    <= '0;
      r_tag2     <= '0;
      r_sticky   <= '0;
    end else begin
      if (w_s1_ready) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_a    <= in_a;
          r_b    <= in_b;
          r_op   <= in_op;
          r_tag1 <= in_tag;
        end
      end
      // result registers only move when S2 can hand over, keeping out_* stable under stall
      if (w_s2_ready) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_res   <= w_res;
          r_flags <= w_flags;
          r_tag2  <= r_tag1;
        end
      end
      if (sticky_clr) r_sticky <= '0;
      else if (r_s2_valid && out_ready) r_sticky <= r_sticky | r_flags[1:0];
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: randomized + directed scoreboard bench for alu_pipe against an arithmetic reference model
module tb_alu_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, sticky_clr = 1'b0;
  logic [31:0] in_a = '0, in_b = '0, out_result;
  logic [2:0]  in_op = '0;
  logic [3:0]  in_tag = '0, out_tag, out_flags;
  logic [1:0]  sticky_cv;
  logic        in_valid8 = 1'b0, in_ready8, out_valid8, sticky_clr8 = 1'b0;
  logic [7:0]  in_a8 = '0, in_b8 = '0, out_result8;
  logic [2:0]  in_op8 = '0;
  logic [3:0]  in_tag8 = '0, out_tag8, out_flags8;
  logic [1:0]  sticky_cv8;
  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
    logic [3:0]  t;
    int          e;
    bit          lat;
  } exp_t;
  exp_t        q[$];
  exp_t        mon_e;
  int          checks = 0, errors = 0, cyc = 0;
  logic [1:0]  sticky_m = '0;
  bit          rnd = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  alu_pipe #(.WIDTH(32), .TAG_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .out_tag(out_tag), .sticky_cv(sticky_cv), .sticky_clr(sticky_clr)
  );
  alu_pipe #(.WIDTH(8), .TAG_W(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_a(in_a8), .in_b(in_b8), .in_op(in_op8), .in_tag(in_tag8),
    .out_valid(out_valid8), .out_ready(1'b1), .out_result(out_result8),
    .out_flags(out_flags8), .out_tag(out_tag8), .sticky_cv(sticky_cv8), .sticky_clr(sticky_clr8)
  );
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask
  // reference: plain integer arithmetic on 64-bit values, {result, N, Z, C, V}
  function automatic logic [35:0] model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    longint ua = a, ub = b, sa = $signed(a), sb = $signed(b), s;
    longint lim = 64'sd2147483647;
    logic [31:0] r;
    bit c = 0, v = 0;
    case (op)
      3'd0: begin s = sa + sb; r = 32'(ua + ub); c = (ua + ub) > 64'hFFFFFFFF; v = s > lim || s < -lim - 1; end
      3'd1: begin s = sa - sb; r = 32'(ua - ub); c = ua >= ub; v = s > lim || s < -lim - 1; end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = 32'((ua + ub) / 2);
      3'd6: r = (sa < sb) ? a : b;
      default: r = (sa < 0) ? 32'd0 : a;
    endcase
    return {r, r[31], r == 32'd0, c, v};
  endfunction
  function automatic void push(logic [2:0] op, logic [31:0] a, logic [31:0] b, logic [3:0] t, bit lat);
    logic [35:0] m = model(op, a, b);
    q.push_back('{m[35:4], m[3:0], t, cyc + 1, lat});
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      4: return 32'h1;
      default: return $urandom;
    endcase
  endfunction
  task automatic step();
    @(negedge clk);
    if (rnd) out_ready = ($urandom_range(0, 3) != 0);
  endtask
  task automatic issue(logic [2:0] op, logic [31:0] a, logic [31:0] b, logic [3:0] t, bit lat);
    bit acc = 0;
    int n = 0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = t;
    while (!acc) begin
      #1;
      acc = in_ready;
      if (acc) push(op, a, b, t, lat);
      step();
      n++;
      if (!acc && n > 200) begin
        checks++; errors++;
        $display("FAIL issue_timeout op %0d not accepted", op);
        break;
      end
    end
    in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin step(); n++; end
    check("drain_empty", q.size(), 0);
    step();
    step();
  endtask
  always @(negedge clk) begin
    #2;
    if (!rst_n) sticky_m = '0;
    else begin
      check("sticky_cv", sticky_cv, sticky_m);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output got %h tag %h want none", out_result, out_tag);
        end else begin
          mon_e = q.pop_front();
          check("result", out_result, mon_e.r);
          check("flags", out_flags, mon_e.f);
          check("tag", out_tag, mon_e.t);
          if (mon_e.lat) check("latency", cyc + 1 - mon_e.e, 2);
        end
      end
      if (sticky_clr) sticky_m = '0;
      else if (out_valid && out_ready && mon_e.r === out_result) sticky_m = sticky_m | mon_e.f[1:0];
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    logic [35:0] ea;
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_flags", out_flags, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_sticky", sticky_cv, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    // WIDTH=8 instance, always-ready consumer
    @(negedge clk);
    in_valid8 = 1'b1; in_op8 = 3'd0; in_a8 = 8'h7F; in_b8 = 8'h01;
    @(negedge clk);
    in_op8 = 3'd5; in_a8 = 8'hFF; in_b8 = 8'hFF;
    @(negedge clk);
    in_valid8 = 1'b0;
    #1;
    check("w8_add_valid", out_valid8, 1);
    check("w8_add_result", out_result8, 8'h80);
    check("w8_add_flags", out_flags8, 4'h9);
    @(negedge clk);
    #1;
    check("w8_mean_result", out_result8, 8'hFF);
    check("w8_mean_flags", out_flags8, 4'h8);
    @(negedge clk);
    // ADD sweep, back-to-back, latency checked
    issue(3'd0, 32'h0, 32'h0, 4'd0, 1);
    issue(3'd0, 32'h0, 32'hFFFFFFFF, 4'd1, 1);
    issue(3'd0, 32'h1, 32'hFFFFFFFF, 4'd2, 1);
    issue(3'd0, 32'hFF, 32'h1, 4'd3, 1);
    drain();
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    issue(3'd1, 32'h0, 32'h0, 4'd4, 1);
    issue(3'd1, 32'h0, 32'hFFFFFFFF, 4'd5, 1);
    issue(3'd1, 32'h100, 32'h1, 4'd6, 1);
    issue(3'd0, 32'h7FFFFFFF, 32'h1, 4'd7, 1);
    drain();
    #1;
    check("sticky_after_sub", sticky_cv, 2'b11);
    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd8, 1);
    issue(3'd3, 32'h0F0F0000, 32'h000000F0, 4'd9, 1);
    issue(3'd4, 32'hFFFFFFFF, 32'h12345678, 4'd10, 1);
    issue(3'd5, 32'h11111111, 32'h1, 4'd11, 1);
    issue(3'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd12, 1);
    issue(3'd6, 32'hFFFFFFFF, 32'h1, 4'd13, 1);
    issue(3'd7, 32'hFFFFFFFF, 32'h5, 4'd14, 1);
    issue(3'd7, 32'h12345678, 32'hFFFFFFFF, 4'd15, 1);
    drain();
    // backpressure: two ops fill the pipe, third must wait
    out_ready = 1'b0;
    issue(3'd0, 32'h00000005, 32'h00000003, 4'd1, 0);
    issue(3'd1, 32'h00000003, 32'h00000005, 4'd2, 0);
    ea = model(3'd0, 32'h5, 32'h3);
    in_valid = 1'b1; in_op = 3'd4; in_a = 32'hA5A5A5A5; in_b = 32'h0F0F0F0F; in_tag = 4'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_stable_result", out_result, ea[35:4]);
      check("bp_stable_flags", out_flags, ea[3:0]);
      check("bp_stable_tag", out_tag, 4'd1);
      step();
    end
    out_ready = 1'b1;
    issue(3'd4, 32'hA5A5A5A5, 32'h0F0F0F0F, 4'd3, 0);
    drain();
    // reset with ops in flight
    out_ready = 1'b0;
    issue(3'd0, 32'h1, 32'h2, 4'd5, 0);
    issue(3'd0, 32'h3, 32'h4, 4'd6, 0);
    step();
    rst_n = 1'b0;
    q.delete();
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_result", out_result, 0);
    check("mid_rst_flags", out_flags, 0);
    check("mid_rst_tag", out_tag, 0);
    check("mid_rst_in_ready", in_ready, 1);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) step();
    check("post_rst_out_valid", out_valid, 0);
    // sticky_clr coinciding with a carrying transfer
    issue(3'd0, 32'h7FFFFFFF, 32'h1, 4'd7, 0);
    drain();
    #1;
    check("sticky_v_set", sticky_cv, 2'b01);
    out_ready = 1'b0;
    issue(3'd0, 32'hFFFFFFFF, 32'h1, 4'd8, 0);
    n = 0;
    while (!out_valid && n < 10) begin step(); n++; end
    check("clr_wait_valid", out_valid, 1);
    out_ready = 1'b1;
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    step();
    #1;
    check("sticky_clr_priority", sticky_cv, 2'b00);
    check("clr_queue_empty", q.size(), 0);
    // randomized traffic with random backpressure
    rnd = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) step();
      issue(3'($urandom_range(0, 7)), pick(), pick(), 4'($urandom), 0);
    end
    rnd = 1'b0;
    out_ready = 1'b1;
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
